prbs15_checker: RTL and testbench

Receive-side PRBS-15 checker that consumes the byte stream produced by the team's PRBS-15 byte generator, or that stream after it returns through the link under test. It self-synchronises an internal x^15+x^14+1 LFSR to the incoming data and declares lock. While locked it counts bit errors and checked bytes. It drops lock and re-hunts after sustained corruption.

---
 rtl/prbs_pkg.sv | 23 ++
 rtl/prbs15_step8.sv | 29 ++
 rtl/prbs15_checker.sv | 135 +++++++++++++
 tb/tb_prbs15_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared constants, state type and helpers for the PRBS-15 (x^15 + x^14 + 1) byte checker.
package prbs_pkg;

    localparam int PRBS15_LEN = 15;
    localparam int TAP_A      = 14;
    localparam int TAP_B      = 13;
    localparam int BYTE_W     = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [3:0] popcount8(input logic [BYTE_W-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < BYTE_W; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs15_step8.sv
// Advances the PRBS-15 state by one byte, MSB first, and produces the predicted byte.
// sel_rx picks received bits (self-synchronising) or predicted bits (free-run) as the shift input.
module prbs15_step8
    import prbs_pkg::*;
(
    input  logic [PRBS15_LEN-1:0] r,
    input  logic [BYTE_W-1:0]     data,
    input  logic                  sel_rx,
    output logic [BYTE_W-1:0]     pred,
    output logic [PRBS15_LEN-1:0] r_next
);

    logic [PRBS15_LEN-1:0] s_work;
    logic                  b_work;

    // r[0] is the newest bit, so the feedback taps sit at the oldest end.
    always_comb begin
        s_work = r;
        b_work = 1'b0;
        pred   = '0;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            b_work  = s_work[TAP_A] ^ s_work[TAP_B];
            pred[i] = b_work;
            s_work  = {s_work[PRBS15_LEN-2:0], (sel_rx ? data[i] : b_work)};
        end
        r_next = s_work;
    end

endmodule

// File: rtl/prbs15_checker.sv
// Receive-side PRBS-15 checker: hunts for lock on the incoming byte stream, then counts
// bit errors and checked bytes with saturating counters until sustained corruption drops lock.
module prbs15_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_BYTES = 4,
    parameter int LOSS_BYTES = 3,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam int SW = CNT_W + 1;

    state_t                state;
    state_t                state_next;
    logic [PRBS15_LEN-1:0] r;
    logic [PRBS15_LEN-1:0] r_step;
    logic [PRBS15_LEN-1:0] r_d;
    logic [BYTE_W-1:0]     pred;
    logic                  sel_rx;
    logic [1:0]            fill;
    logic [1:0]            fill_d;
    logic [3:0]            match_cnt;
    logic [3:0]            match_d;
    logic [3:0]            bad_cnt;
    logic [3:0]            bad_d;
    logic [3:0]            err_bits;
    logic                  err_d;
    logic [CNT_W-1:0]      bit_err_d;
    logic [CNT_W-1:0]      byte_d;
    logic [CNT_W:0]        bit_sum;
    logic [CNT_W:0]        byte_sum;

    assign sel_rx = (state == HUNT);

    prbs15_step8 u_step (
        .r      (r),
        .data   (data_in),
        .sel_rx (sel_rx),
        .pred   (pred),
        .r_next (r_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            locked      <= 1'b0;
            r           <= '0;
            fill        <= 2'd0;
            match_cnt   <= 4'd0;
            bad_cnt     <= 4'd0;
            err_pulse   <= 1'b0;
            bit_err_cnt <= '0;
            byte_cnt    <= '0;
        end else begin
            state       <= state_next;
            locked      <= (state_next == LOCKED);
            r           <= r_d;
            fill        <= fill_d;
            match_cnt   <= match_d;
            bad_cnt     <= bad_d;
            err_pulse   <= err_d;
            bit_err_cnt <= bit_err_d;
            byte_cnt    <= byte_d;
        end
    end

    // One extra sum bit catches overflow so the counters pin at all-ones instead of wrapping.
    always_comb begin
        state_next = state;
        r_d        = r;
        fill_d     = fill;
        match_d    = match_cnt;
        bad_d      = bad_cnt;
        err_d      = 1'b0;
        err_bits   = popcount8(pred ^ data_in);
        bit_sum    = {1'b0, bit_err_cnt} + SW'(err_bits);
        byte_sum   = {1'b0, byte_cnt} + SW'(1);
        bit_err_d  = bit_err_cnt;
        byte_d     = byte_cnt;

        if (data_valid) begin
            r_d = r_step;
            case (state)
                HUNT: begin
                    if (fill != 2'd2) begin
                        fill_d = fill + 2'd1;
                    end else if ((pred == data_in) && (r != '0)) begin
                        if (match_cnt == 4'(LOCK_BYTES - 1)) begin
                            state_next = LOCKED;
                            match_d    = 4'd0;
                        end else begin
                            match_d = match_cnt + 4'd1;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    bit_err_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                    byte_d    = byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
                    if (err_bits != 4'd0) begin
                        err_d = 1'b1;
                        if (bad_cnt == 4'(LOSS_BYTES - 1)) begin
                            state_next = HUNT;
                            fill_d     = 2'd0;
                            match_d    = 4'd0;
                            bad_d      = 4'd0;
                        end else begin
                            bad_d = bad_cnt + 4'd1;
                        end
                    end else begin
                        bad_d = 4'd0;
                    end
                end
                default: state_next = HUNT;
            endcase
        end

        if (clear) begin
            bit_err_d = '0;
            byte_d    = '0;
        end
    end

endmodule

// File: tb/tb_prbs15_checker.sv
// Randomised and directed bench for prbs15_checker; a wide and a 4-bit-counter instance share stimulus
// and are compared every cycle against a sequence-level reference model.
module tb_prbs15_checker;

    localparam int LOCK_BYTES = 4;
    localparam int LOSS_BYTES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_err_cnt;
    logic [31:0] byte_cnt;
    logic        locked_s;
    logic        err_pulse_s;
    logic [3:0]  bit_err_cnt_s;
    logic [3:0]  byte_cnt_s;

    int checks   = 0;
    int failures = 0;
    int pulse_seen;
    bit zero_lock_seen;

    bit     gen_q[$];
    bit     hist[$];
    bit     m_locked;
    bit     m_err;
    int     m_fill;
    int     m_match;
    int     m_bad;
    longint m_bit;
    longint m_byte;

    always #5 clk = ~clk;

    prbs15_checker #(.LOCK_BYTES(LOCK_BYTES), .LOSS_BYTES(LOSS_BYTES), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .clear       (clear),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .bit_err_cnt (bit_err_cnt),
        .byte_cnt    (byte_cnt)
    );

    prbs15_checker #(.LOCK_BYTES(LOCK_BYTES), .LOSS_BYTES(LOSS_BYTES), .CNT_W(4)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .clear       (clear),
        .locked      (locked_s),
        .err_pulse   (err_pulse_s),
        .bit_err_cnt (bit_err_cnt_s),
        .byte_cnt    (byte_cnt_s)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic void gen_seed();
        gen_q.delete();
        repeat (15) gen_q.push_back(1'b1);
    endfunction

    // s[k] = s[k-14] ^ s[k-15]; queue index 0 holds s[k-15].
    function automatic logic [7:0] gen_byte();
        logic [7:0] b;
        bit nb;
        for (int i = 7; i >= 0; i--) begin
            nb = gen_q[0] ^ gen_q[1];
            b[i] = nb;
            gen_q.push_back(nb);
            void'(gen_q.pop_front());
        end
        return b;
    endfunction

    function automatic void model_reset();
        hist.delete();
        repeat (15) hist.push_back(1'b0);
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_fill   = 0;
        m_match  = 0;
        m_bad    = 0;
        m_bit    = 0;
        m_byte   = 0;
    endfunction

    function automatic void model_step(input logic [7:0] d, input bit v, input bit c);
        bit         all_zero;
        bit         nb;
        logic [7:0] pred;
        int         e;
        m_err = 1'b0;
        if (v) begin
            all_zero = 1'b1;
            foreach (hist[i]) if (hist[i]) all_zero = 1'b0;
            for (int i = 7; i >= 0; i--) begin
                nb = hist[0] ^ hist[1];
                pred[i] = nb;
                hist.push_back(m_locked ? nb : d[i]);
                void'(hist.pop_front());
            end
            if (!m_locked) begin
                if (m_fill < 2) m_fill++;
                else if (pred == d && !all_zero) begin
                    m_match++;
                    if (m_match == LOCK_BYTES) begin
                        m_locked = 1'b1;
                        m_match  = 0;
                    end
                end else m_match = 0;
            end else begin
                e = $countones(pred ^ d);
                m_bit  += e;
                m_byte += 1;
                if (e != 0) begin
                    m_err = 1'b1;
                    m_bad++;
                    if (m_bad == LOSS_BYTES) begin
                        m_locked = 1'b0;
                        m_fill   = 0;
                        m_match  = 0;
                        m_bad    = 0;
                    end
                end else m_bad = 0;
            end
        end
        if (c) begin
            m_bit  = 0;
            m_byte = 0;
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input bit v, input bit c);
        data_in    = d;
        data_valid = v;
        clear      = c;
        @(posedge clk);
        #1;
        model_step(d, v, c);
        if (err_pulse === 1'b1) pulse_seen++;
        if (locked === 1'b1) zero_lock_seen = 1'b1;
        checkOutput("locked", 64'(locked), 64'(m_locked));
        checkOutput("err_pulse", 64'(err_pulse), 64'(m_err));
        checkOutput("bit_err_cnt", 64'(bit_err_cnt), 64'(sat(m_bit, 64'hFFFF_FFFF)));
        checkOutput("byte_cnt", 64'(byte_cnt), 64'(sat(m_byte, 64'hFFFF_FFFF)));
        checkOutput("locked_s", 64'(locked_s), 64'(m_locked));
        checkOutput("err_pulse_s", 64'(err_pulse_s), 64'(m_err));
        checkOutput("bit_err_cnt_s", 64'(bit_err_cnt_s), 64'(sat(m_bit, 15)));
        checkOutput("byte_cnt_s", 64'(byte_cnt_s), 64'(sat(m_byte, 15)));
    endtask

    task automatic sendClean(input int n);
        repeat (n) applyStimulus(gen_byte(), 1'b1, 1'b0);
    endtask

    task automatic sendErr(input logic [7:0] mask);
        applyStimulus(gen_byte() ^ mask, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        rst        = 1'b1;
        data_in    = 8'h00;
        data_valid = 1'b0;
        clear      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_locked", 64'(locked), 64'd0);
        checkOutput("reset_err_pulse", 64'(err_pulse), 64'd0);
        checkOutput("reset_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("reset_byte_cnt", 64'(byte_cnt), 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        doReset();

        // clean lock from seed 7FFF
        gen_seed();
        sendClean(5);
        checkOutput("lock_before_6th", 64'(locked), 64'd0);
        sendClean(1);
        checkOutput("lock_at_6th", 64'(locked), 64'd1);
        sendClean(20);
        checkOutput("clean_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("clean_byte_cnt", 64'(byte_cnt), 64'd20);

        // single then 3-bit error
        pulse_seen = 0;
        sendErr(8'h01);
        checkOutput("err1_cnt", 64'(bit_err_cnt), 64'd1);
        checkOutput("err1_pulse", 64'(err_pulse), 64'd1);
        sendClean(1);
        checkOutput("pulse_one_cycle", 64'(err_pulse), 64'd0);
        sendClean(3);
        sendErr(8'h92);
        checkOutput("err3_cnt", 64'(bit_err_cnt), 64'd4);
        sendClean(2);
        checkOutput("err_pulses_total", 64'(pulse_seen), 64'd2);
        checkOutput("still_locked", 64'(locked), 64'd1);

        // loss and relock
        sendErr(8'hFF);
        sendErr(8'hFF);
        checkOutput("locked_after_2_bad", 64'(locked), 64'd1);
        sendErr(8'hFF);
        checkOutput("loss_at_3rd", 64'(locked), 64'd0);
        checkOutput("loss_bits", 64'(bit_err_cnt), 64'd28);
        checkOutput("loss_bytes", 64'(byte_cnt), 64'd31);
        sendClean(5);
        checkOutput("relock_before", 64'(locked), 64'd0);
        sendClean(1);
        checkOutput("relock", 64'(locked), 64'd1);

        // clear beats a same-cycle errored byte
        sendClean(2);
        applyStimulus(gen_byte() ^ 8'h10, 1'b1, 1'b1);
        checkOutput("clear_bit", 64'(bit_err_cnt), 64'd0);
        checkOutput("clear_byte", 64'(byte_cnt), 64'd0);

        // 20 bit errors saturate the 4-bit instance
        sendErr(8'hFF);
        sendClean(1);
        sendErr(8'hFF);
        sendClean(1);
        sendErr(8'h0F);
        checkOutput("sat_small", 64'(bit_err_cnt_s), 64'hF);
        checkOutput("sat_big", 64'(bit_err_cnt), 64'd20);
        sendClean(20);
        checkOutput("sat_byte_small", 64'(byte_cnt_s), 64'hF);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("clear_idle", 64'(bit_err_cnt_s), 64'd0);

        // asynchronous reset while locked
        sendClean(8);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_locked", 64'(locked), 64'd0);
        checkOutput("async_rst_bits", 64'(bit_err_cnt), 64'd0);
        checkOutput("async_rst_bytes", 64'(byte_cnt), 64'd0);
        checkOutput("async_rst_bytes_s", 64'(byte_cnt_s), 64'd0);
        #1;
        rst = 1'b0;
        model_reset();
        sendClean(5);
        checkOutput("rst_relock_before", 64'(locked), 64'd0);
        sendClean(1);
        checkOutput("rst_relock", 64'(locked), 64'd1);

        // all-zero stream never locks
        doReset();
        zero_lock_seen = 1'b0;
        repeat (100) applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("zero_never_locked", 64'(zero_lock_seen), 64'd0);

        // clean stream with random gaps matches the gap-free result
        doReset();
        gen_seed();
        for (int sent = 0; sent < 40; ) begin
            if ($urandom_range(0, 2) == 0) applyStimulus(8'($urandom), 1'b0, 1'b0);
            else begin
                applyStimulus(gen_byte(), 1'b1, 1'b0);
                sent++;
            end
        end
        checkOutput("gap_locked", 64'(locked), 64'd1);
        checkOutput("gap_bit_err", 64'(bit_err_cnt), 64'd0);
        checkOutput("gap_byte_cnt", 64'(byte_cnt), 64'd34);

        // random errors, gaps and clears against the model
        for (int i = 0; i < 400; i++) begin
            logic [7:0] mask;
            bit v;
            v    = ($urandom_range(0, 3) != 0);
            mask = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (v) applyStimulus(gen_byte() ^ mask, 1'b1, ($urandom_range(0, 39) == 0));
            else   applyStimulus(8'($urandom), 1'b0, ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
